// File: rtl/cmp_minmax_track.sv
// Streaming unsigned min/max tracker with valid/ready in and out handshakes.
// Optional CMP_MINMAX_IDX_EN adds max_idx/min_idx (first-occurrence index of each extreme).
module cmp_minmax_track #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] max_val,
  output logic [WIDTH-1:0] min_val,
  output logic [CNT_W-1:0] count,
`ifdef CMP_MINMAX_IDX_EN
  output logic [CNT_W-1:0] max_idx,
  output logic [CNT_W-1:0] min_idx,
`endif
  output logic             busy
);

  // state  | meaning
  // S_IDLE | waiting for start; last result retained
  // S_RUN  | accepting samples, updating running max/min/count
  // S_HOLD | result presented on out_valid until out_ready
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;
  logic [WIDTH-1:0] r_max;
  logic [WIDTH-1:0] r_min;
  logic [CNT_W-1:0] r_count;
`ifdef CMP_MINMAX_IDX_EN
  logic [CNT_W-1:0] r_max_idx;
  logic [CNT_W-1:0] r_min_idx;
`endif

  logic w_accept;
  logic w_first;
  logic w_sat;

  // in_ready is a registered copy of (state == RUN), so accept needs no state decode
  assign w_accept = in_valid & r_in_ready;
  assign w_first  = (r_count == '0);
  assign w_sat    = &r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_max       <= '0;
      r_min       <= '0;
      r_count     <= '0;
`ifdef CMP_MINMAX_IDX_EN
      r_max_idx   <= '0;
      r_min_idx   <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state    <= S_RUN;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
            r_max      <= '0;
            r_min      <= '0;
            r_count    <= '0;
`ifdef CMP_MINMAX_IDX_EN
            r_max_idx  <= '0;
            r_min_idx  <= '0;
`endif
          end
        end

        S_RUN: begin
          if (w_accept) begin
            if (w_first) begin
              r_max <= in_data;
              r_min <= in_data;
`ifdef CMP_MINMAX_IDX_EN
              r_max_idx <= r_count;
              r_min_idx <= r_count;
`endif
            end else begin
              if (in_data > r_max) begin
                r_max <= in_data;
`ifdef CMP_MINMAX_IDX_EN
                if (!w_sat) r_max_idx <= r_count;
`endif
              end
              if (in_data < r_min) begin
                r_min <= in_data;
`ifdef CMP_MINMAX_IDX_EN
                if (!w_sat) r_min_idx <= r_count;
`endif
              end
            end
            if (!w_sat) r_count <= r_count + CNT_ONE;
            if (in_last) begin
              r_state     <= S_HOLD;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
            end
          end
        end

        S_HOLD: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        end

        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign max_val   = r_max;
  assign min_val   = r_min;
  assign count     = r_count;
`ifdef CMP_MINMAX_IDX_EN
  assign max_idx   = r_max_idx;
  assign min_idx   = r_min_idx;
`endif

endmodule
